multiplicador_4b_seq: RTL and testbench



---
 rtl/multiplicador_4b_seq_if.sv | 26 ++
 rtl/multiplicador_4b_seq.sv | 106 ++++++++++
 tb/tb_multiplicador_4b_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/multiplicador_4b_seq_if.sv
// Operand/result bundle for multiplicador_4b_seq: start strobe with operands in,
// busy/done/product out, plus the FSM state for observation.
interface multiplicador_4b_seq_if;
  // Handshake: start is a one-cycle strobe that is honoured only when the unit
  // is idle or in its done cycle; A and B are captured on that same edge.
  // done is a one-cycle pulse marking P valid; P then holds until the next
  // accepted start. busy is high for the whole iteration and starts are
  // ignored while it is set. No output depends combinationally on start/A/B.
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] P;
  logic [1:0] state;

  modport master (
    output start, A, B,
    input  busy, done, P, state
  );

  modport slave (
    input  start, A, B,
    output busy, done, P, state
  );
endinterface

// File: rtl/multiplicador_4b_seq.sv
// Sequential shift-and-add 4x4 unsigned multiplier built around one sumador_4b.
// Optional macro MULT_ZERO_SKIP_EN: a zero operand finishes in one cycle.

module sumador_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c
);
  assign {c, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module multiplicador_4b_seq (
  input  logic              clk,
  input  logic              rst_n,
  multiplicador_4b_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] m;
  logic [3:0] q;
  logic [3:0] hi;
  logic [1:0] cnt;
  logic [7:0] p;
  logic [3:0] sum;
  logic       carry;
  logic [7:0] shifted;
  logic       accept;
  logic       skip;

  sumador_4b u_add (
    .a   (hi),
    .b   (m),
    .cin (1'b0),
    .s   (sum),
    .c   (carry)
  );

  assign accept = bus.start && ((state == IDLE) || (state == DONE));

`ifdef MULT_ZERO_SKIP_EN
  assign skip = accept && ((bus.A == 4'd0) || (bus.B == 4'd0));
`else
  assign skip = 1'b0;
`endif

  // The adder carry becomes the top bit of the new Hi; losing it breaks 15*15.
  always_comb begin
    shifted = {1'b0, hi, q[3:1]};
    if (q[0]) shifted = {carry, sum, q[3:1]};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = skip ? DONE : RUN;
      end
      RUN: begin
        if (cnt == 2'd3) state_next = DONE;
      end
      DONE: begin
        if (accept) state_next = skip ? DONE : RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= 4'd0;
      q   <= 4'd0;
      hi  <= 4'd0;
      cnt <= 2'd0;
      p   <= 8'h00;
    end else if (accept) begin
      m   <= bus.A;
      q   <= bus.B;
      hi  <= 4'd0;
      cnt <= 2'd0;
      if (skip) p <= 8'h00;
    end else if (state == RUN) begin
      {hi, q} <= shifted;
      cnt     <= cnt + 2'd1;
      if (cnt == 2'd3) p <= shifted;
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.P     = p;
  assign bus.state = state;
endmodule

// File: tb/tb_multiplicador_4b_seq.sv
// Self-checking bench for multiplicador_4b_seq: directed cases, an asynchronous
// reset mid-run, and a shuffled sweep of all 256 operand pairs.
module tb_multiplicador_4b_seq;
`ifdef MULT_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];
  logic [7:0] last_p;

  multiplicador_4b_seq_if bus ();

  multiplicador_4b_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: issue one operation and follow it to its done pulse.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b);
    int lat;
    logic [7:0] exp;
    lat = (ZERO_SKIP && (a == 4'd0 || b == 4'd0)) ? 0 : 4;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    exp_q.push_back(8'(a * b));
    tick();
    bus.start = 1'b0;
    bus.A     = 4'($urandom_range(0, 15));
    bus.B     = 4'($urandom_range(0, 15));
    for (int i = 0; i < lat; i++) begin
      check("busy_run", {7'd0, bus.busy}, 8'd1);
      check("done_run", {7'd0, bus.done}, 8'd0);
      check("p_held_run", bus.P, last_p);
      tick();
    end
    exp = exp_q.pop_front();
    check("done_pulse", {7'd0, bus.done}, 8'd1);
    check("busy_done", {7'd0, bus.busy}, 8'd0);
    check("product", bus.P, exp);
    last_p = exp;
  endtask

  task automatic idle_tick();
    tick();
    check("done_width", {7'd0, bus.done}, 8'd0);
    check("busy_idle", {7'd0, bus.busy}, 8'd0);
    check("p_held_idle", bus.P, last_p);
  endtask

  // Stimulus
  initial begin
    int mult;
    int off;
    int idx;
    checks    = 0;
    errors    = 0;
    last_p    = 8'h00;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 4'd0;
    bus.B     = 4'd0;
    repeat (3) tick();
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    check("rst_done", {7'd0, bus.done}, 8'd0);
    check("rst_p", bus.P, 8'h00);
    check("rst_state", {6'd0, bus.state}, 8'd0);
    rst_n = 1'b1;
    tick();

    run_op(4'd3, 4'd5);
    check("p_3x5", bus.P, 8'h0F);
    idle_tick();
    idle_tick();

    run_op(4'd15, 4'd15);
    check("p_15x15", bus.P, 8'hE1);
    idle_tick();

    run_op(4'd0, 4'd9);
    check("p_0x9", bus.P, 8'h00);
    idle_tick();

    // Start during RUN is ignored; start in the DONE cycle is accepted.
    bus.start = 1'b1;
    bus.A = 4'd7;
    bus.B = 4'd6;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.A = 4'd2;
    bus.B = 4'd2;
    tick();
    bus.start = 1'b0;
    check("ignored_busy", {7'd0, bus.busy}, 8'd1);
    tick();
    tick();
    check("done_7x6", {7'd0, bus.done}, 8'd1);
    check("p_7x6", bus.P, 8'h2A);
    last_p = 8'h2A;
    run_op(4'd2, 4'd2);
    check("p_2x2", bus.P, 8'h04);
    idle_tick();

    // Asynchronous reset in the middle of RUN (cnt == 2).
    bus.start = 1'b1;
    bus.A = 4'd9;
    bus.B = 4'd9;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {7'd0, bus.busy}, 8'd0);
    check("arst_done", {7'd0, bus.done}, 8'd0);
    check("arst_p", bus.P, 8'h00);
    check("arst_state", {6'd0, bus.state}, 8'd0);
    tick();
    #2;
    rst_n = 1'b1;
    last_p = 8'h00;
    for (int i = 0; i < 8; i++) idle_tick();

    // Shuffled sweep over every operand pair via an odd-multiplier permutation.
    mult = ($urandom_range(0, 127) * 2) + 1;
    off  = $urandom_range(0, 255);
    for (int i = 0; i < 256; i++) begin
      idx = (i * mult + off) & 255;
      run_op(4'(idx >> 4), 4'(idx & 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < $urandom_range(1, 2); g++) idle_tick();
      end
    end
    idle_tick();
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
